// File: rtl/systolic_tile_engine.sv
// Output-stationary ROWS x COLS systolic tile: C = A * B with internal operand
// skew, fixed drain and row-by-row result readback.
module systolic_tile_engine #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32,
    parameter int K_WIDTH   = 8,
    parameter int SIGNED    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [K_WIDTH-1:0]        k_len,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*IN_WIDTH-1:0]  a_col,
    input  logic [COLS*IN_WIDTH-1:0]  b_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*OUT_WIDTH-1:0] out_row,
    output logic [$clog2(ROWS)-1:0]   out_row_idx,
    output logic                      out_last
);

    localparam int IW = $clog2(ROWS);
    localparam int DW = $clog2(ROWS + COLS);
    localparam logic [DW-1:0] DLAST = DW'(ROWS + COLS - 2);

    if (OUT_WIDTH < 2 * IN_WIDTH) begin : g_bad_width
        $error("OUT_WIDTH must be at least 2*IN_WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [K_WIDTH-1:0]   r_klen;
    logic [K_WIDTH-1:0]   r_beat_cnt;
    logic [DW-1:0]        r_dcnt;
    logic [IW-1:0]        r_idx;

    logic [IN_WIDTH-1:0]  w_a_src [ROWS];
    logic                 w_a_srcv [ROWS];
    logic [IN_WIDTH-1:0]  w_b_src [COLS];
    logic                 w_b_srcv [COLS];

    logic [IN_WIDTH-1:0]  r_a   [ROWS][COLS];
    logic                 r_av  [ROWS][COLS];
    logic [IN_WIDTH-1:0]  r_b   [ROWS][COLS];
    logic                 r_bv  [ROWS][COLS];
    logic [OUT_WIDTH-1:0] r_acc [ROWS][COLS];

    logic w_beat;
    logic w_clr;
    logic w_last_beat;
    logic w_drain_done;
    logic w_out_hs;
    logic w_out_end;

    assign w_beat       = in_valid && (r_state == S_LOAD);
    assign w_clr        = start && (r_state == S_IDLE);
    assign w_last_beat  = w_beat && (r_beat_cnt == r_klen - K_WIDTH'(1));
    assign w_drain_done = (r_state == S_DRAIN) && (r_dcnt == DLAST);
    assign w_out_hs     = (r_state == S_OUT) && out_ready;
    assign w_out_end    = w_out_hs && (r_idx == IW'(ROWS - 1));

    // Extending both operands to OUT_WIDTH first gives the wrapped sum directly.
    function automatic logic [OUT_WIDTH-1:0] f_mul(
        input logic [IN_WIDTH-1:0] a,
        input logic [IN_WIDTH-1:0] b
    );
        logic [OUT_WIDTH-1:0] ea;
        logic [OUT_WIDTH-1:0] eb;
        logic                 sa;
        logic                 sb;
        sa = (SIGNED != 0) && a[IN_WIDTH-1];
        sb = (SIGNED != 0) && b[IN_WIDTH-1];
        ea = {{(OUT_WIDTH - IN_WIDTH){sa}}, a};
        eb = {{(OUT_WIDTH - IN_WIDTH){sb}}, b};
        return ea * eb;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = (k_len == '0) ? S_OUT : S_LOAD;
            S_LOAD:  if (w_last_beat) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_next = S_OUT;
            S_OUT:   if (w_out_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE:  ;
            S_LOAD:  begin busy = 1'b1; in_ready = 1'b1; end
            S_DRAIN: busy = 1'b1;
            S_OUT:   begin busy = 1'b1; out_valid = 1'b1; end
            default: ;
        endcase
    end

    assign out_last    = out_valid && (r_idx == IW'(ROWS - 1));
    assign out_row_idx = r_idx;

    always_comb begin
        out_row = '0;
        for (int c = 0; c < COLS; c++)
            out_row[c*OUT_WIDTH +: OUT_WIDTH] = r_acc[r_idx][c];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_klen     <= '0;
            r_beat_cnt <= '0;
            r_dcnt     <= '0;
            r_idx      <= '0;
        end else begin
            if (w_clr) begin
                r_klen     <= k_len;
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + K_WIDTH'(1);
            end
            r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + DW'(1) : '0;
            if (w_out_end)     r_idx <= '0;
            else if (w_out_hs) r_idx <= r_idx + IW'(1);
        end
    end

    // Row r of A and column c of B are delayed r and c cycles respectively.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        if (r == 0) begin : g_direct
            assign w_a_src[r]  = a_col[r*IN_WIDTH +: IN_WIDTH];
            assign w_a_srcv[r] = w_beat;
        end else begin : g_dly
            logic [IN_WIDTH-1:0] r_d [r];
            logic                r_v [r];
            always_ff @(posedge clk) begin
                if (reset || w_clr) begin
                    for (int k = 0; k < r; k++) begin
                        r_d[k] <= '0;
                        r_v[k] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= a_col[r*IN_WIDTH +: IN_WIDTH];
                    r_v[0] <= w_beat;
                    for (int k = 1; k < r; k++) begin
                        r_d[k] <= r_d[k-1];
                        r_v[k] <= r_v[k-1];
                    end
                end
            end
            assign w_a_src[r]  = r_d[r-1];
            assign w_a_srcv[r] = r_v[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        if (c == 0) begin : g_direct
            assign w_b_src[c]  = b_row[c*IN_WIDTH +: IN_WIDTH];
            assign w_b_srcv[c] = w_beat;
        end else begin : g_dly
            logic [IN_WIDTH-1:0] r_d [c];
            logic                r_v [c];
            always_ff @(posedge clk) begin
                if (reset || w_clr) begin
                    for (int k = 0; k < c; k++) begin
                        r_d[k] <= '0;
                        r_v[k] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= b_row[c*IN_WIDTH +: IN_WIDTH];
                    r_v[0] <= w_beat;
                    for (int k = 1; k < c; k++) begin
                        r_d[k] <= r_d[k-1];
                        r_v[k] <= r_v[k-1];
                    end
                end
            end
            assign w_b_src[c]  = r_d[c-1];
            assign w_b_srcv[c] = r_v[c-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_a[r][c]   <= '0;
                    r_av[r][c]  <= 1'b0;
                    r_b[r][c]   <= '0;
                    r_bv[r][c]  <= 1'b0;
                    r_acc[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                r_a[r][0]  <= w_a_src[r];
                r_av[r][0] <= w_a_srcv[r];
                for (int c = 1; c < COLS; c++) begin
                    r_a[r][c]  <= r_a[r][c-1];
                    r_av[r][c] <= r_av[r][c-1];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                r_b[0][c]  <= w_b_src[c];
                r_bv[0][c] <= w_b_srcv[c];
                for (int r = 1; r < ROWS; r++) begin
                    r_b[r][c]  <= r_b[r-1][c];
                    r_bv[r][c] <= r_bv[r-1][c];
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (r_av[r][c] && r_bv[r][c])
                        r_acc[r][c] <= r_acc[r][c] + f_mul(r_a[r][c], r_b[r][c]);
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: 3x3 unsigned, 3x3 signed and a
// 16-bit accumulator variant share one stimulus stream.
module tb_systolic_tile_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  k_len = '0;
    logic        in_valid = 1'b0;
    logic [23:0] a_col = '0;
    logic [23:0] b_row = '0;
    logic        out_ready = 1'b1;

    logic        busy0, in_ready0, out_valid0, last0;
    logic [95:0] row0;
    logic [1:0]  idx0;
    logic        busy1, in_ready1, out_valid1, last1;
    logic [95:0] row1;
    logic [1:0]  idx1;
    logic        busy2, in_ready2, out_valid2, last2;
    logic [47:0] row2;
    logic [1:0]  idx2;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] AC [3] = '{24'h070401, 24'h080502, 24'h090603};
    logic [23:0] BR [3] = '{24'h030201, 24'h060504, 24'h090807};
    logic [95:0] T1_ROWS [3] = '{
        {32'd42, 32'd36, 32'd30},
        {32'd96, 32'd81, 32'd66},
        {32'd150, 32'd126, 32'd102}
    };
    logic [95:0] exp_rows [3];

    always #5 clk = ~clk;

    systolic_tile_engine #(
        .ROWS(3), .COLS(3), .IN_WIDTH(8), .OUT_WIDTH(32), .K_WIDTH(8), .SIGNED(0)
    ) u0 (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy0),
        .in_valid(in_valid), .in_ready(in_ready0), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid0), .out_ready(out_ready), .out_row(row0),
        .out_row_idx(idx0), .out_last(last0)
    );

    systolic_tile_engine #(
        .ROWS(3), .COLS(3), .IN_WIDTH(8), .OUT_WIDTH(32), .K_WIDTH(8), .SIGNED(1)
    ) u1 (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy1),
        .in_valid(in_valid), .in_ready(in_ready1), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid1), .out_ready(out_ready), .out_row(row1),
        .out_row_idx(idx1), .out_last(last1)
    );

    systolic_tile_engine #(
        .ROWS(3), .COLS(3), .IN_WIDTH(8), .OUT_WIDTH(16), .K_WIDTH(8), .SIGNED(0)
    ) u2 (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy2),
        .in_valid(in_valid), .in_ready(in_ready2), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid2), .out_ready(out_ready), .out_row(row2),
        .out_row_idx(idx2), .out_last(last2)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] k);
        start = 1'b1;
        k_len = k;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            a_col = AC[i];
            b_row = BR[i];
            chk("in_ready_beat", 96'(in_ready0), 96'd1);
            step();
            in_valid = 1'b0;
            if (i < n - 1) begin
                repeat (gap) begin
                    chk("in_ready_gap", 96'(in_ready0), 96'd1);
                    step();
                end
            end
        end
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid0 && n < 60) begin
            step();
            n++;
        end
        chk("out_valid_wait", 96'(out_valid0), 96'd1);
    endtask

    task automatic collect(input int hold_row, input int hold_n);
        wait_out();
        for (int i = 0; i < 3; i++) begin
            chk("row", row0, exp_rows[i]);
            chk("row_idx", 96'(idx0), 96'(i));
            chk("out_last", 96'(last0), 96'(i == 2));
            if (i == hold_row) begin
                out_ready = 1'b0;
                repeat (hold_n) begin
                    step();
                    chk("hold_row", row0, exp_rows[i]);
                    chk("hold_idx", 96'(idx0), 96'(i));
                    chk("hold_valid", 96'(out_valid0), 96'd1);
                end
                out_ready = 1'b1;
            end
            step();
        end
        chk("busy_after", 96'(busy0), 96'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", 96'(busy0), 96'd0);
        chk("rst_in_ready", 96'(in_ready0), 96'd0);
        chk("rst_out_valid", 96'(out_valid0), 96'd0);
        chk("rst_out_last", 96'(last0), 96'd0);
        chk("rst_out_row", row0, 96'd0);
        chk("rst_idx", 96'(idx0), 96'd0);
        reset = 1'b0;
        step();

        // T1: back-to-back beats
        exp_rows = T1_ROWS;
        start_job(8'd3);
        feed(3, 0);
        chk("t1_drain_ready", 96'(in_ready0), 96'd0);
        chk("t1_drain_busy", 96'(busy0), 96'd1);
        collect(-1, 0);

        // T2: two bubble cycles between beats
        start_job(8'd3);
        feed(3, 2);
        collect(-1, 0);

        // T3: back-pressure on row 1
        start_job(8'd3);
        feed(3, 0);
        collect(1, 5);

        // T4a: 0xFF * 2, unsigned vs signed
        start_job(8'd1);
        in_valid = 1'b1;
        a_col = 24'h0000FF;
        b_row = 24'h000002;
        step();
        in_valid = 1'b0;
        wait_out();
        chk("t4_unsigned", row0, {64'd0, 32'd510});
        chk("t4_signed", row1, {64'd0, 32'hFFFFFFFE});
        repeat (3) step();
        chk("t4a_busy", 96'(busy0), 96'd0);

        // T4b: 16-bit accumulator wrap, k_len=2 all 255
        start_job(8'd2);
        in_valid = 1'b1;
        a_col = 24'hFFFFFF;
        b_row = 24'hFFFFFF;
        step();
        step();
        in_valid = 1'b0;
        wait_out();
        for (int i = 0; i < 3; i++) begin
            chk("t4_wrap16", 96'(row2), 96'({3{16'hFC02}}));
            chk("t4_full32", row0, {3{32'd130050}});
            chk("t4_signed_m1", row1, {3{32'd2}});
            step();
        end
        chk("t4b_busy", 96'(busy0), 96'd0);

        // T5: reset mid-load, then rerun
        start_job(8'd3);
        feed(2, 0);
        reset = 1'b1;
        step();
        chk("t5_busy", 96'(busy0), 96'd0);
        chk("t5_in_ready", 96'(in_ready0), 96'd0);
        chk("t5_out_valid", 96'(out_valid0), 96'd0);
        reset = 1'b0;
        step();
        start_job(8'd3);
        feed(3, 0);
        collect(-1, 0);

        // T6: k_len=0, then start and stray beat during DRAIN
        exp_rows = '{96'd0, 96'd0, 96'd0};
        start_job(8'd0);
        chk("t6_skip_load", 96'(out_valid0), 96'd1);
        collect(-1, 0);
        exp_rows = T1_ROWS;
        start_job(8'd3);
        feed(3, 0);
        start = 1'b1;
        k_len = 8'd0;
        in_valid = 1'b1;
        a_col = 24'hFFFFFF;
        b_row = 24'hFFFFFF;
        step();
        start = 1'b0;
        in_valid = 1'b0;
        chk("t6_drain_start", 96'(out_valid0), 96'd0);
        chk("t6_drain_ready", 96'(in_ready0), 96'd0);
        collect(-1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
